// File: rtl/pll_reset_sequencer_pkg.sv
//------------------------------------------------------------------------------
// pll_reset_pkg: shared state encoding and widths for pll_reset_sequencer. rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pll_reset_pkg;

   localparam int LOSS_CNT_W = 8;

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      SETTLE     = 3'd1,
      SDRAM_INIT = 3'd2,
      RUN        = 3'd3,
      FAULT      = 3'd4
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
//------------------------------------------------------------------------------
// pll_reset_sequencer_if: lock/init inputs and reset/status outputs of the sequencer. rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pll_reset_sequencer_if;
   import pll_reset_pkg::*;

   logic                  pll_locked;
   logic                  sdram_init_done;
   logic                  sdram_rst_n;
   logic                  core_rst_n;
   logic                  ready;
   logic                  fault;
   logic [LOSS_CNT_W-1:0] lock_loss_count;

   modport master (
      input  pll_locked,
      input  sdram_init_done,
      output sdram_rst_n,
      output core_rst_n,
      output ready,
      output fault,
      output lock_loss_count
   );

   modport slave (
      output pll_locked,
      output sdram_init_done,
      input  sdram_rst_n,
      input  core_rst_n,
      input  ready,
      input  fault,
      input  lock_loss_count
   );

endinterface

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
//------------------------------------------------------------------------------
// sync_2ff: 1-bit two-flop synchronizer, synchronous active-low reset to 0. rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic d_i,
   output logic      q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
//------------------------------------------------------------------------------
// pll_reset_sequencer: ordered SDRAM then core reset release from PLL lock;
// lock-loss counter built only when LOCK_LOSS_COUNT_EN is defined. rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pll_reset_sequencer #(
   parameter int SETTLE_CYCLES = 1024,
   parameter int INIT_TIMEOUT  = 65536,
   parameter int FAULT_HOLD    = 256
) (
   input  wire logic                clk,
   input  wire logic                reset_n,
   pll_reset_sequencer_if.master    bus
);
   import pll_reset_pkg::*;

   localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, INIT_TIMEOUT, FAULT_HOLD));
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FAULT_LAST  = CNT_W'(FAULT_HOLD - 1);

   logic             lock_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sdram_rst_n_q, sdram_rst_n_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;

   sync_2ff u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (bus.pll_locked),
      .q_o     (lock_s)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= WAIT_LOCK;
         cnt_q         <= '0;
         sdram_rst_n_q <= 1'b0;
         core_rst_n_q  <= 1'b0;
         ready_q       <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sdram_rst_n_q <= sdram_rst_n_d;
         core_rst_n_q  <= core_rst_n_d;
         ready_q       <= ready_d;
         fault_q       <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_s) state_d = SETTLE;
         end
         SETTLE: begin
            if (!lock_s)                 state_d = WAIT_LOCK;
            else if (cnt_q == SETTLE_LAST) state_d = SDRAM_INIT;
         end
         SDRAM_INIT: begin
            // lock loss outranks init done, which outranks the timeout
            if (!lock_s)                 state_d = WAIT_LOCK;
            else if (bus.sdram_init_done) state_d = RUN;
            else if (cnt_q == INIT_LAST) state_d = FAULT;
         end
         RUN: begin
            if (!lock_s) state_d = WAIT_LOCK;
         end
         FAULT: begin
            if (cnt_q == FAULT_LAST) state_d = WAIT_LOCK;
         end
         default: state_d = WAIT_LOCK;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == SETTLE || state_q == SDRAM_INIT || state_q == FAULT) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end

      // outputs decoded from the next state so they move on the transition edge
      sdram_rst_n_d = (state_d == SDRAM_INIT) || (state_d == RUN);
      core_rst_n_d  = (state_d == RUN);
      ready_d       = (state_d == RUN);
      fault_d       = (state_d == FAULT);
   end

   assign bus.sdram_rst_n = sdram_rst_n_q;
   assign bus.core_rst_n  = core_rst_n_q;
   assign bus.ready       = ready_q;
   assign bus.fault       = fault_q;

`ifdef LOCK_LOSS_COUNT_EN
   logic                  lock_prev_q;
   logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (lock_prev_q && !lock_s && (loss_cnt_q != '1)) begin
         loss_cnt_d = loss_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lock_prev_q <= 1'b0;
         loss_cnt_q  <= '0;
      end else begin
         lock_prev_q <= lock_s;
         loss_cnt_q  <= loss_cnt_d;
      end
   end

   assign bus.lock_loss_count = loss_cnt_q;
`else
   assign bus.lock_loss_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
//------------------------------------------------------------------------------
// tb_pll_reset_sequencer: directed scenarios plus random lock/init traffic
// checked every cycle against a phase/elapsed-time reference model. rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pll_reset_sequencer;

   localparam int SETTLE_CYCLES = 8;
   localparam int INIT_TIMEOUT  = 16;
   localparam int FAULT_HOLD    = 4;

`ifdef LOCK_LOSS_COUNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   localparam int P_WAIT   = 0;
   localparam int P_SETTLE = 1;
   localparam int P_INIT   = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAULT  = 4;

   logic clk = 1'b0;
   logic reset_n;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .INIT_TIMEOUT  (INIT_TIMEOUT),
      .FAULT_HOLD    (FAULT_HOLD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: which phase the sequencer is in and how many edges it has spent there.
   int m_phase;
   int m_spent;
   int m_losses;
   bit m_prev_ls;
   bit m_hist[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] dut_outs();
      return {bus.sdram_rst_n, bus.core_rst_n, bus.ready, bus.fault, bus.lock_loss_count};
   endfunction

   function automatic logic [11:0] m_outs();
      logic [7:0] c;
      c = (CNT_ON != 0) ? 8'(m_losses) : 8'd0;
      return {(m_phase == P_INIT) || (m_phase == P_RUN), m_phase == P_RUN,
              m_phase == P_RUN, m_phase == P_FAULT, c};
   endfunction

   task automatic model_update(input bit pl, input bit idn, input bit rn);
      bit ls;
      bit fell;
      int nxt;
      if (!rn) begin
         m_hist.delete();
         m_hist.push_back(1'b0);
         m_hist.push_back(1'b0);
         m_phase   = P_WAIT;
         m_spent   = 0;
         m_losses  = 0;
         m_prev_ls = 1'b0;
         return;
      end
      ls   = m_hist[0];              // the lock level as sampled two edges ago
      fell = m_prev_ls && !ls;
      m_prev_ls = ls;
      void'(m_hist.pop_front());
      m_hist.push_back(pl);
      if (fell && m_losses < 255) m_losses++;
      nxt = m_phase;
      case (m_phase)
         P_WAIT:   if (ls) nxt = P_SETTLE;
         P_SETTLE: if (!ls) nxt = P_WAIT;
                   else if (m_spent + 1 == SETTLE_CYCLES) nxt = P_INIT;
         P_INIT:   if (!ls) nxt = P_WAIT;
                   else if (idn) nxt = P_RUN;
                   else if (m_spent + 1 == INIT_TIMEOUT) nxt = P_FAULT;
         P_RUN:    if (!ls) nxt = P_WAIT;
         P_FAULT:  if (m_spent + 1 == FAULT_HOLD) nxt = P_WAIT;
         default:  nxt = P_WAIT;
      endcase
      m_spent = (nxt != m_phase) ? 0 : m_spent + 1;
      m_phase = nxt;
   endtask

   task automatic step(input bit pl, input bit idn, input bit rn);
      bus.pll_locked      = pl;
      bus.sdram_init_done = idn;
      reset_n             = rn;
      @(posedge clk);
      model_update(pl, idn, rn);
      #1;
      check("outs_vs_model", 32'(dut_outs()), 32'(m_outs()));
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("reset_outs", 32'(dut_outs()), 32'd0);
   endtask

   initial begin
      int first_a, first_b, first_c, last_f, rise_n, second_rise;
      bit prev_sd, seen, pl, idn, rn;

      bus.pll_locked      = 1'b0;
      bus.sdram_init_done = 1'b0;
      reset_n             = 1'b0;

      // Normal bring-up: lock at edge 1, init_done from edge 16
      do_reset();
      first_a = -1; first_b = -1; first_c = -1;
      for (int k = 1; k <= 24; k++) begin
         step(1'b1, k >= 16, 1'b1);
         if (bus.sdram_rst_n && first_a < 0) first_a = k;
         if (bus.core_rst_n && first_b < 0) first_b = k;
         if (bus.ready && first_c < 0) first_c = k;
      end
      check("bringup_sdram_edge", first_a, 11);
      check("bringup_core_edge", first_b, 16);
      check("bringup_ready_edge", first_c, 16);

      // Lock loss in RUN: all resets back within 3 edges, then relock
      first_a = -1;
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 1'b1, 1'b1);
         if (!bus.sdram_rst_n && !bus.core_rst_n && !bus.ready && first_a < 0) first_a = k;
      end
      check("runloss_drop_edge", first_a, 3);
      check("runloss_count", bus.lock_loss_count, CNT_ON);
      first_a = -1;
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 1'b1, 1'b1);
         if (bus.ready && first_a < 0) first_a = k;
      end
      check("relock_ready_edge", first_a, 12);

      // Settle glitch: lock dropped for edges 5..7
      do_reset();
      first_a = -1;
      for (int k = 1; k <= 30; k++) begin
         step(!(k >= 5 && k <= 7), 1'b0, 1'b1);
         if (bus.sdram_rst_n && first_a < 0) first_a = k;
      end
      check("glitch_sdram_edge", first_a, 18);
      check("glitch_count", bus.lock_loss_count, CNT_ON);

      // Init timeout: fault edges 27..30, then re-sequence
      do_reset();
      first_a = -1; last_f = -1; rise_n = 0; second_rise = -1; prev_sd = 1'b0; seen = 1'b0;
      for (int k = 1; k <= 42; k++) begin
         step(1'b1, 1'b0, 1'b1);
         if (bus.fault && first_a < 0) first_a = k;
         if (bus.fault) last_f = k;
         if (bus.fault && bus.sdram_rst_n) seen = 1'b1;
         if (bus.sdram_rst_n && !prev_sd) begin
            rise_n++;
            if (rise_n == 2) second_rise = k;
         end
         prev_sd = bus.sdram_rst_n;
      end
      check("timeout_fault_edge", first_a, 27);
      check("timeout_fault_last", last_f, 30);
      check("timeout_sdram_in_fault", seen, 0);
      check("timeout_reseq_edge", second_rise, 40);

      // Simultaneous lock loss and init done at edge 14
      do_reset();
      seen = 1'b0; first_a = -1;
      for (int k = 1; k <= 30; k++) begin
         step(k < 12, k >= 14, 1'b1);
         if (bus.core_rst_n) seen = 1'b1;
         if (k > 11 && !bus.sdram_rst_n && first_a < 0) first_a = k;
      end
      check("simul_core_never", seen, 0);
      check("simul_drop_edge", first_a, 14);

      // Counter saturation with 300 lock pulses
      do_reset();
      for (int i = 0; i < 600; i++) step(i % 2 == 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
      check("sat_count", bus.lock_loss_count, (CNT_ON != 0) ? 255 : 0);

      // Reset asserted mid-RUN
      for (int k = 1; k <= 20; k++) step(1'b1, 1'b1, 1'b1);
      check("pre_reset_ready", bus.ready, 1);
      step(1'b1, 1'b1, 1'b0);
      check("midrun_reset_outs", 32'(dut_outs()), 32'd0);

      // Random traffic against the model
      do_reset();
      pl = 1'b0; idn = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 23) == 0) pl = ~pl;
         if ($urandom_range(0, 9) == 0) idn = ~idn;
         rn = ($urandom_range(0, 799) != 0);
         step(pl, idn, rn);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
